reg_scoreboard: RTL and testbench

Tracks in-flight register writes for the 8-entry, 16-bit register file and generates the decode-stage stall. Sits directly upstream of `rf_bypass`. Decode presents each candidate instruction's source and destination selects. The scoreboard grants issue only when no older, unretired producer owns a source register. The writeback stage reports retirements using the same select/strobe pair that drives the register file's write port.

---
 rtl/reg_scoreboard.sv | 100 ++++++++++
 tb/tb_reg_scoreboard.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the 8-entry register file: counts in-flight
// producers per register and raises the decode stall on RAW or counter-full hazards.
module reg_scoreboard #(
  parameter int CNT_W     = 2,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_valid,
  input  logic [2:0] issue_rs_sel,
  input  logic       issue_rs_used,
  input  logic [2:0] issue_rt_sel,
  input  logic       issue_rt_used,
  input  logic [2:0] issue_rd_sel,
  input  logic       issue_rd_write,
  input  logic       wb_valid,
  input  logic [2:0] wb_sel,
  input  logic       flush,
  output logic       issue_ack,
  output logic       stall,
  output logic [7:0] busy,
  output logic       err
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] cnt_view [8];
  logic [7:0]       underflow;
  logic             rs_hazard;
  logic             rt_hazard;
  logic             struct_hazard;
  logic             err_q;
  logic             err_d;

  // A lone producer retiring this cycle is forwarded by the register file.
  always_comb begin
    rs_hazard = issue_rs_used && (cnt_view[issue_rs_sel] != CNT_ZERO) &&
                !(WB_BYPASS && wb_valid && (wb_sel == issue_rs_sel) &&
                  (cnt_view[issue_rs_sel] == CNT_ONE));
    rt_hazard = issue_rt_used && (cnt_view[issue_rt_sel] != CNT_ZERO) &&
                !(WB_BYPASS && wb_valid && (wb_sel == issue_rt_sel) &&
                  (cnt_view[issue_rt_sel] == CNT_ONE));
    struct_hazard = issue_rd_write && (cnt_view[issue_rd_sel] == CNT_MAX) &&
                    !(wb_valid && (wb_sel == issue_rd_sel));
  end

  assign stall     = issue_valid & (rs_hazard | rt_hazard | struct_hazard | flush);
  assign issue_ack = issue_valid & ~stall;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_reg
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             inc;
      logic             dec;

      assign inc = issue_ack & issue_rd_write & (issue_rd_sel == 3'(gi));
      assign dec = wb_valid & (wb_sel == 3'(gi)) & ~flush;

      always_comb begin
        cnt_d         = cnt_q;
        underflow[gi] = dec && (cnt_q == CNT_ZERO);
        if (flush) begin
          cnt_d = CNT_ZERO;
        end else if (inc && !dec) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (dec && !inc && (cnt_q != CNT_ZERO)) begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= CNT_ZERO;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_view[gi] = cnt_q;
      assign busy[gi]     = (cnt_q != CNT_ZERO);
    end
  endgenerate

  assign err_d = err_q | (|underflow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Table-driven check of reg_scoreboard, run side by side with and without
// writeback bypass; registered expectations flow through a scoreboard queue.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid;
  logic [2:0] issue_rs_sel;
  logic       issue_rs_used;
  logic [2:0] issue_rt_sel;
  logic       issue_rt_used;
  logic [2:0] issue_rd_sel;
  logic       issue_rd_write;
  logic       wb_valid;
  logic [2:0] wb_sel;
  logic       flush;
  logic       ack1, stall1, err1;
  logic       ack0, stall0, err0;
  logic [7:0] busy1, busy0;

  always #5 clk = ~clk;

  reg_scoreboard #(.CNT_W(2), .WB_BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .issue_rs_sel(issue_rs_sel), .issue_rs_used(issue_rs_used),
    .issue_rt_sel(issue_rt_sel), .issue_rt_used(issue_rt_used),
    .issue_rd_sel(issue_rd_sel), .issue_rd_write(issue_rd_write),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .flush(flush),
    .issue_ack(ack1), .stall(stall1), .busy(busy1), .err(err1)
  );

  reg_scoreboard #(.CNT_W(2), .WB_BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .issue_rs_sel(issue_rs_sel), .issue_rs_used(issue_rs_used),
    .issue_rt_sel(issue_rt_sel), .issue_rt_used(issue_rt_used),
    .issue_rd_sel(issue_rd_sel), .issue_rd_write(issue_rd_write),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .flush(flush),
    .issue_ack(ack0), .stall(stall0), .busy(busy0), .err(err0)
  );

  typedef struct {
    string      name;
    logic       valid;
    logic [2:0] rs;
    logic       rsu;
    logic [2:0] rt;
    logic       rtu;
    logic [2:0] rd;
    logic       rdw;
    logic       wbv;
    logic [2:0] wbs;
    logic       fl;
    logic       stall1;
    logic       stall0;
    logic [7:0] busy;
    logic       err;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] busy;
    logic       err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input string nm, input logic v, input logic [2:0] rs, input logic rsu,
                     input logic [2:0] rt, input logic rtu, input logic [2:0] rd, input logic rdw,
                     input logic wbv, input logic [2:0] wbs, input logic fl,
                     input logic s1, input logic s0, input logic [7:0] b, input logic e);
    vec_t t;
    t.name = nm; t.valid = v; t.rs = rs; t.rsu = rsu; t.rt = rt; t.rtu = rtu;
    t.rd = rd; t.rdw = rdw; t.wbv = wbv; t.wbs = wbs; t.fl = fl;
    t.stall1 = s1; t.stall0 = s0; t.busy = b; t.err = e;
    vecs.push_back(t);
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs_sel = 0; issue_rs_used = 0; issue_rt_sel = 0;
    issue_rt_used = 0; issue_rd_sel = 0; issue_rd_write = 0;
    wb_valid = 0; wb_sel = 0; flush = 0;
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic apply(input vec_t t);
    exp_t e;
    issue_valid = t.valid; issue_rs_sel = t.rs; issue_rs_used = t.rsu;
    issue_rt_sel = t.rt; issue_rt_used = t.rtu; issue_rd_sel = t.rd;
    issue_rd_write = t.rdw; wb_valid = t.wbv; wb_sel = t.wbs; flush = t.fl;
    e.name = t.name; e.busy = t.busy; e.err = t.err;
    sb.push_back(e);
    #3;
    chk({t.name, " stall"},      8'(stall1), 8'(t.stall1));
    chk({t.name, " ack"},        8'(ack1),   8'(t.valid & ~t.stall1));
    chk({t.name, " stall_nobyp"}, 8'(stall0), 8'(t.stall0));
    chk({t.name, " ack_nobyp"},   8'(ack0),   8'(t.valid & ~t.stall0));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({t.name, " sb_empty"}, 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      chk({e.name, " busy"},       busy1,      e.busy);
      chk({e.name, " err"},        8'(err1),   8'(e.err));
      chk({e.name, " busy_nobyp"}, busy0,      e.busy);
      chk({e.name, " err_nobyp"},  8'(err0),   8'(e.err));
    end
    $display("txn %-14s stall=%b/%b ack=%b/%b busy=%h err=%b", t.name,
             stall1, stall0, ack1, ack0, busy1, err1);
  endtask

  initial begin
    //   name           v rs u rt u rd w wb ws f  s1 s0 busy   err
    add("iss_r3",       1, 0,1, 0,0, 3,1, 0,0, 0, 0, 0, 8'h08, 0);
    add("dep_r3",       1, 3,1, 0,0, 0,0, 0,0, 0, 1, 1, 8'h08, 0);
    add("byp_r3",       1, 3,1, 0,0, 0,0, 1,3, 0, 0, 1, 8'h00, 0);
    add("dep_r3_free",  1, 3,1, 0,0, 0,0, 0,0, 0, 0, 0, 8'h00, 0);
    add("iss_r5_a",     1, 0,0, 0,0, 5,1, 0,0, 0, 0, 0, 8'h20, 0);
    add("iss_r5_b",     1, 0,0, 0,0, 5,1, 0,0, 0, 0, 0, 8'h20, 0);
    add("iss_r5_c",     1, 0,0, 0,0, 5,1, 0,0, 0, 0, 0, 8'h20, 0);
    add("struct_r5",    1, 0,0, 0,0, 5,1, 0,0, 0, 1, 1, 8'h20, 0);
    add("struct_wb_r5", 1, 0,0, 0,0, 5,1, 1,5, 0, 0, 0, 8'h20, 0);
    add("unused_src",   1, 5,0, 5,0, 0,0, 0,0, 0, 0, 0, 8'h20, 0);
    add("rt_haz",       1, 0,0, 5,1, 0,0, 0,0, 0, 1, 1, 8'h20, 0);
    add("drain_r5_a",   0, 0,0, 0,0, 0,0, 1,5, 0, 0, 0, 8'h20, 0);
    add("nobyp_cnt2",   1, 5,1, 0,0, 0,0, 1,5, 0, 1, 1, 8'h20, 0);
    add("drain_r5_c",   0, 0,0, 0,0, 0,0, 1,5, 0, 0, 0, 8'h00, 0);
    add("iss_r1",       1, 0,0, 0,0, 1,1, 0,0, 0, 0, 0, 8'h02, 0);
    add("iss_r4",       1, 0,0, 0,0, 4,1, 0,0, 0, 0, 0, 8'h12, 0);
    add("iss_r7",       1, 0,0, 0,0, 7,1, 0,0, 0, 0, 0, 8'h92, 0);
    add("flush",        1, 0,0, 0,0, 6,1, 1,2, 1, 1, 1, 8'h00, 0);
    add("under_r2",     0, 0,0, 0,0, 0,0, 1,2, 0, 0, 0, 8'h00, 1);
    add("err_sticky",   0, 0,0, 0,0, 0,0, 0,0, 0, 0, 0, 8'h00, 1);
    add("iss_r4b",      1, 0,0, 0,0, 4,1, 0,0, 0, 0, 0, 8'h10, 1);
    add("iss_r5b",      1, 0,0, 0,0, 5,1, 0,0, 0, 0, 0, 8'h30, 1);
    add("iss_r6b",      1, 0,0, 0,0, 6,1, 0,0, 0, 0, 0, 8'h70, 1);
    add("iss_r7b",      1, 0,0, 0,0, 7,1, 0,0, 0, 0, 0, 8'hF0, 1);

    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("reset busy",  busy1,      8'h00);
    chk("reset err",   8'(err1),   8'h00);
    chk("reset stall", 8'(stall1), 8'h00);
    chk("reset ack",   8'(ack1),   8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Asynchronous reset between edges must clear state before the next edge.
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst busy",       busy1,    8'h00);
    chk("async_rst err",        8'(err1), 8'h00);
    chk("async_rst busy_nobyp", busy0,    8'h00);
    $display("txn %-14s busy=%h err=%b", "async_rst", busy1, err1);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vecs.delete();
    add("post_rst_r2", 1, 2,1, 0,0, 2,1, 0,0, 0, 0, 0, 8'h04, 0);
    apply(vecs[0]);

    if (sb.size() != 0) chk("sb_leftover", 8'(sb.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
